uart_program_loader: RTL

Receives a program image over the board UART line and writes it, one 16-bit instruction per write, into the processor's instruction memory. It sits directly upstream of instruction memory and the PC controller. It drives the instruction write port and raises `load_done`, which releases the PC from its hold. After `load_done` the block ignores the serial line until reset.

---
 rtl/loader_pkg.sv | 21 ++
 rtl/uart_rx_byte.sv | 91 +++++++++
 rtl/uart_program_loader.sv | 104 ++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types for the UART program loader: receiver and loader state
// encodings plus the default baud divisor.
package loader_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 868;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      L_COUNT,
      L_HI,
      L_LO,
      L_DONE
   } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop line synchronizer, mid-bit sampling FSM,
// one-cycle byte_valid pulse after a good stop bit.
module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       UART_TXD_IN,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       stop_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [1:0]       sync_q;
   logic             line;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_d;

   assign line      = sync_q[1];
   assign byte_data = shift_q;

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path infers a latch.
      state_d  = state_q;
      baud_d   = baud_q + CNT_W'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      valid_d  = 1'b0;
      stop_err = 1'b0;
      case (state_q)
         RX_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (!line) state_d = RX_START;
         end
         RX_START: begin
            // A line that is high again at mid-bit was a glitch, not a start bit.
            if (baud_q == HALF_LAST) begin
               baud_d  = '0;
               state_d = line ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (baud_q == FULL_LAST) begin
               baud_d  = '0;
               shift_d = {line, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (baud_q == FULL_LAST) begin
               baud_d   = '0;
               state_d  = RX_IDLE;
               valid_d  = line;
               stop_err = !line;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (RST) begin
         sync_q     <= 2'b11;
         state_q    <= RX_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_valid <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], UART_TXD_IN};
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_valid <= valid_d;
      end
   end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a count-prefixed program image from the UART into instruction
// memory, one {hi,lo} word per write, then releases the PC via load_done.
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              UART_TXD_IN,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              load_done,
   output logic              frame_error
);

   logic       byte_valid;
   logic [7:0] byte_data;
   logic       stop_err;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .CLK        (CLK),
      .RST        (RST),
      .UART_TXD_IN(UART_TXD_IN),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .stop_err   (stop_err)
   );

   ld_state_t         state_q, state_d;
   logic [7:0]        count_q, count_d;
   logic [7:0]        hi_q, hi_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              wr_fire;
   logic              done_set;
   logic              last_word;

   assign last_word = (32'(idx_q) == 32'(count_q) - 32'd1);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      hi_d     = hi_q;
      idx_d    = idx_q;
      wr_fire  = 1'b0;
      done_set = (state_q == L_DONE);
      case (state_q)
         L_COUNT: begin
            if (byte_valid) begin
               count_d  = byte_data;
               state_d  = (byte_data == 8'd0) ? L_DONE : L_HI;
               // An empty image completes one cycle earlier than a real one.
               done_set = (byte_data == 8'd0);
            end
         end
         L_HI: begin
            if (byte_valid) begin
               hi_d    = byte_data;
               state_d = L_LO;
            end
         end
         L_LO: begin
            if (byte_valid) begin
               wr_fire = 1'b1;
               idx_d   = idx_q + ADDR_W'(1);
               state_d = last_word ? L_DONE : L_HI;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= L_COUNT;
         count_q     <= '0;
         hi_q        <= '0;
         idx_q       <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         load_done   <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         idx_q     <= idx_d;
         wr_en     <= wr_fire;
         load_done <= load_done | done_set;
         if (wr_fire) begin
            wr_addr <= idx_q;
            wr_data <= DATA_W'({hi_q, byte_data});
         end
         if (stop_err && state_q != L_DONE) frame_error <= 1'b1;
      end
   end

endmodule
